// File: rtl/sem_channel_pkg.sv
// ---------------------------------------------------------------------------
// sem_channel_pkg
// Shared definitions for the semaphore channel responder.
//   SEM_DATA_WIDTH : default token width
//   SEM_DEPTH      : default number of FIFO entries (output register excluded)
//   SEM_PTR_WIDTH  : log2(SEM_DEPTH)
//   out_state_e    : output register state codes (empty / holding a token)
// ---------------------------------------------------------------------------
package sem_channel_pkg;

  localparam int SEM_DATA_WIDTH = 1;
  localparam int SEM_DEPTH      = 4;
  localparam int SEM_PTR_WIDTH  = 2;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/sem_fifo_mem.sv
// ---------------------------------------------------------------------------
// sem_fifo_mem
// Token storage behind the channel's output register.
// The caller only asserts push/pop when the operation is legal, so this block
// never checks for overflow or underflow itself.
// Ports:
//   clk     : clock, all updates on posedge
//   rst     : asynchronous active-low reset (pointers and count cleared)
//   push    : store wr_data at wr_ptr this edge
//   pop     : advance rd_ptr this edge (head is consumed)
//   wr_data : token to store
//   head    : token at rd_ptr
//   count   : number of stored tokens, 0..DEPTH
//   full    : count == DEPTH
// ---------------------------------------------------------------------------
module sem_fifo_mem
  import sem_channel_pkg::*;
#(
  parameter int DATA_WIDTH = SEM_DATA_WIDTH,
  parameter int DEPTH      = SEM_DEPTH,
  parameter int PTR_WIDTH  = SEM_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
  // push and pop leaves the count untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];
  assign full = (count == (PTR_WIDTH+1)'(DEPTH));

endmodule

// File: rtl/sem_channel.sv
// ---------------------------------------------------------------------------
// sem_channel
// Responder end of the semaphore interface. Tokens written by a producer
// bit_unit are buffered and presented to a consumer bit_unit through an
// output register. When nothing is buffered a write bypasses the FIFO and
// lands straight in the output register, giving one-edge latency.
// Optional build macro: SEM_OVF_EN adds the sticky sem_overflow output.
// Ports:
//   clk                : clock
//   rst                : asynchronous active-low reset, discards all tokens
//   wr_data            : token from the producer's sem_data_out
//   wr_valid           : one-cycle write strobe (producer's sem_data_valid_out)
//   sem_data_empty     : no token held in FIFO or output register
//   sem_full           : FIFO holds DEPTH tokens
//   sem_data_out       : head token to the consumer's sem_data_in
//   sem_data_valid_out : head token valid (consumer's sem_data_valid_in)
//   sem_data_read      : consumer pop strobe, ignored when nothing is valid
//   sem_overflow       : (SEM_OVF_EN only) set when a write is dropped, sticky
// ---------------------------------------------------------------------------
module sem_channel
  import sem_channel_pkg::*;
#(
  parameter int DATA_WIDTH = SEM_DATA_WIDTH,
  parameter int DEPTH      = SEM_DEPTH,
  parameter int PTR_WIDTH  = SEM_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  sem_data_empty,
  output logic                  sem_full,
  output logic [DATA_WIDTH-1:0] sem_data_out,
  output logic                  sem_data_valid_out,
`ifdef SEM_OVF_EN
  output logic                  sem_overflow,
`endif
  input  logic                  sem_data_read
);

  out_state_e            state_q;
  out_state_e            state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  wr_to_fifo;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [PTR_WIDTH:0]    fifo_count;
  logic                  fifo_full;

  sem_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  // Output register and its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Decide what the output register takes next and whether the write strobe
  // is routed into the FIFO. Buffered tokens always win over the bypass path
  // so ordering is preserved. A write that wants the FIFO is accepted when
  // there is room, or when the head is being dequeued on the same edge.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    fifo_pop   = 1'b0;
    wr_to_fifo = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (fifo_count != '0) begin
          data_d     = fifo_head;
          fifo_pop   = 1'b1;
          wr_to_fifo = wr_valid;
          state_d    = OUT_VALID;
        end else if (wr_valid) begin
          data_d  = wr_data;
          state_d = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (sem_data_read) begin
          if (fifo_count != '0) begin
            data_d     = fifo_head;
            fifo_pop   = 1'b1;
            wr_to_fifo = wr_valid;
          end else if (wr_valid) begin
            data_d = wr_data;
          end else begin
            state_d = OUT_EMPTY;
          end
        end else begin
          wr_to_fifo = wr_valid;
        end
      end
    endcase
    fifo_push = wr_to_fifo && (!fifo_full || fifo_pop);
  end

`ifdef SEM_OVF_EN
  logic wr_drop;
  assign wr_drop = wr_to_fifo && fifo_full && !fifo_pop;

  // Sticky record that at least one write was lost since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sem_overflow <= 1'b0;
    end else if (wr_drop) begin
      sem_overflow <= 1'b1;
    end
  end
`endif

  assign sem_data_out       = data_q;
  assign sem_data_valid_out = (state_q == OUT_VALID);
  assign sem_data_empty     = (state_q == OUT_EMPTY) && (fifo_count == '0);
  assign sem_full           = fifo_full;

endmodule

// File: tb/tb_sem_channel.sv
// ---------------------------------------------------------------------------
// tb_sem_channel
// Directed self-checking bench for sem_channel (default parameters).
// ---------------------------------------------------------------------------
module tb_sem_channel;

  logic       clk;
  logic       rst;
  logic [0:0] wr_data;
  logic       wr_valid;
  logic       sem_data_empty;
  logic       sem_full;
  logic [0:0] sem_data_out;
  logic       sem_data_valid_out;
  logic       sem_data_read;
`ifdef SEM_OVF_EN
  logic       sem_overflow;
`endif

  int checks;
  int errors;

  // Reference queue: element 0 is the token expected in the output register.
  logic model_q [$];

  sem_channel dut (
    .clk                (clk),
    .rst                (rst),
    .wr_data            (wr_data),
    .wr_valid           (wr_valid),
    .sem_data_empty     (sem_data_empty),
    .sem_full           (sem_full),
    .sem_data_out       (sem_data_out),
    .sem_data_valid_out (sem_data_valid_out),
`ifdef SEM_OVF_EN
    .sem_overflow       (sem_overflow),
`endif
    .sem_data_read      (sem_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then release them.
  task automatic applyStimulus(input logic wv, input logic wd, input logic rd);
    wr_valid      = wv;
    wr_data       = wd;
    sem_data_read = rd;
    @(posedge clk);
    #1;
    wr_valid      = 1'b0;
    wr_data       = 1'b0;
    sem_data_read = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic d,
                          input logic e, input logic f);
    checkOutput({tag, "_valid"}, 8'(sem_data_valid_out), 8'(v));
    if (v) checkOutput({tag, "_data"}, 8'(sem_data_out), 8'(d));
    checkOutput({tag, "_empty"}, 8'(sem_data_empty), 8'(e));
    checkOutput({tag, "_full"}, 8'(sem_full), 8'(f));
  endtask

  initial begin
    logic d;
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    wr_valid      = 1'b0;
    wr_data       = 1'b0;
    sem_data_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data", 8'(sem_data_out), 8'h0);
    checkAll("rst", 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SEM_OVF_EN
    checkOutput("rst_ovf", 8'(sem_overflow), 8'h0);
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("idle", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] bypass");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("byp_wr", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("byp_pop", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] order and fill");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("fill1", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("fill2", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("fill3", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("fill4", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("fill5", 1'b1, 1'b1, 1'b0, 1'b1);

    $display("[TB] full handling");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("drop", 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef SEM_OVF_EN
    checkOutput("drop_ovf", 8'(sem_overflow), 8'h1);
`endif
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkAll("full_wrpop", 1'b1, 1'b0, 1'b0, 1'b1);

    // Remaining tokens: 1,1,0 from the original writes then the accepted 0.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("drain1", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("drain2", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("drain3", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("drain4", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("drain5", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] wrap-around");
    model_q.delete();
    applyStimulus(1'b1, 1'b1, 1'b0);
    model_q.push_back(1'b1);
    checkAll("wrap_p1", 1'b1, model_q[0], 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    model_q.push_back(1'b0);
    checkAll("wrap_p2", 1'b1, model_q[0], 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      d = (i % 2 == 0);
      applyStimulus(1'b1, d, 1'b1);
      model_q.push_back(d);
      void'(model_q.pop_front());
      checkAll($sformatf("wrap%0d", i), 1'b1, model_q[0], 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    void'(model_q.pop_front());
    checkAll("wrap_d1", 1'b1, model_q[0], 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("wrap_d2", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] spurious read");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("spur1", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("spur2", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("spur_wr", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("spur_pop", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkAll("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_data", 8'(sem_data_out), 8'h0);
    checkAll("async_rst", 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SEM_OVF_EN
    checkOutput("async_ovf", 8'(sem_overflow), 8'h0);
`endif
    @(posedge clk);
    #3;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("post_rst", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAll("post_rst_rd", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sem_channel.md
Name: sem_channel

Overview:
- Responder end of the controller's semaphore interface.
- One bit_unit writes tokens through its `sem_data_out` / `sem_data_valid_out` pins; this block buffers them in a small FIFO.
- It presents them to the consuming bit_unit's `sem_data_in` / `sem_data_valid_in` / `sem_data_read` pins, and reports `sem_data_empty` back.
- Sits between two bit_units, or loops back to the same unit.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (1): token width.
- DEPTH, default 4: FIFO entries, excluding the output register; power of two, ≥2.
- PTR_WIDTH, default 2: log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- wr_data  input  DATA_WIDTH  token from the producer controller's sem_data_out.
- wr_valid  input  1  one-cycle write strobe from the producer's sem_data_valid_out.
- sem_data_empty  output  1  high when no token is held anywhere (FIFO and output register).
- sem_full  output  1  high when FIFO count == DEPTH.
- sem_data_out  output  DATA_WIDTH  token at the head, to the consumer's sem_data_in.
- sem_data_valid_out  output  1  head token valid, to the consumer's sem_data_valid_in.
- sem_data_read  input  1  consumer pop strobe (consumer's sem_data_read).

Behaviour:
- Reset (async, rst=0) values:
  - sem_data_out=0, sem_data_valid_out=0, sem_data_empty=1, sem_full=0.
  - rd_ptr=wr_ptr=0, count=0, out state=OUT_EMPTY.
  - Reset mid-operation discards all tokens.
- Output state machine, 2 states:
  - OUT_EMPTY: valid_out=0.
  - OUT_VALID: valid_out=1; sem_data_out is stable until popped.
- Each wr_valid-high cycle is one write. Back-to-back strobes give back-to-back writes.
- Pop: sem_data_read=1 while in OUT_VALID. sem_data_read while in OUT_EMPTY is ignored.
- OUT_EMPTY transitions:
  - FIFO count>0: load head into the output register and go to OUT_VALID next edge; rd_ptr++, count--.
  - Else, wr_valid=1: bypass wr_data straight into the output register and go to OUT_VALID. The FIFO is not written.
  - Latency is one edge from a write strobe to valid_out.
- OUT_VALID with pop:
  - FIFO count>0: refill from the head in the same edge and stay in OUT_VALID. Valid stays high, giving back-to-back tokens.
  - count==0 and wr_valid=1: bypass-refill with wr_data.
  - Otherwise go to OUT_EMPTY.
- OUT_VALID without pop: a write goes to the FIFO at wr_ptr; wr_ptr++, count++.
- Full handling:
  - A write with count==DEPTH and no same-edge FIFO dequeue is dropped; pointers are unchanged.
  - A write with count==DEPTH and a same-edge dequeue (pop+refill) is accepted; count is unchanged.
- Pointers are PTR_WIDTH bits and wrap DEPTH-1 → 0. count is PTR_WIDTH+1 bits.
- sem_data_empty = (state==OUT_EMPTY) && (count==0), registered consistently with state.
- sem_full = (count==DEPTH).
- Simultaneous write and pop is always legal. FIFO order is strictly preserved; bypass only occurs when the FIFO is empty.

Optional Feature:
- Macro: SEM_OVF_EN.
- Defined:
  - Adds output sem_overflow (1 bit), reset 0.
  - Set on the edge a write is dropped; sticky until rst.
- Undefined:
  - Port absent; drops are silent.
  - Functional behaviour otherwise identical.

Decomposition:
- Shared include definy.v gains:
  - SEM_DEPTH default.
  - State codes `SEM_OUT_EMPTY=1'b0 and `SEM_OUT_VALID=1'b1.
  - Reuses `DATA_WIDTH.
- One sub-module: sem_fifo_mem, holding storage array, wr_ptr/rd_ptr/count, push/pop enables, head data and full.
- sem_channel holds the output register, state machine, bypass muxing and flags.

Test Plan:
- Reset check: assert rst=0 mid-stream with 3 tokens held → all outputs at reset values immediately (async); after release, empty=1, valid_out=0.
- Bypass: from empty, wr_data=1, wr_valid one cycle → next edge valid_out=1, sem_data_out=1, empty=0. Pop one cycle → valid_out=0, empty=1.
- Order and fill:
  - Write 1,0,1,1,0 with no pops → output holds 1; full=1 after the 5th write (4 in FIFO).
  - Pop 5 consecutive cycles → sem_data_out sequence 1,0,1,1,0 with valid_out continuously high, then 0.
- Full plus simultaneous:
  - At full, write 1 with no pop → dropped; sem_overflow=1 if SEM_OVF_EN.
  - At full, write 0 with a pop → accepted; full stays 1, and the drained sequence ends with 0.
- Wrap-around: 10 interleaved write/pop pairs with alternating data → pointers wrap twice and data order is preserved.
- Spurious read: sem_data_read=1 while empty → no state change, empty stays 1, no underflow of count.
